// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: an operand capture register feeds
// one lookahead group per stage, with the inter-group carry registered between stages.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_0,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int NSTG     = WIDTH / GROUP;
    // Stage k keeps (k+1) groups of finished sum and NSTG-1-k groups of pending
    // operand bits; both are packed back to back into flat triangular vectors.
    localparam int SUM_BITS = GROUP * NSTG * (NSTG + 1) / 2;
    localparam int REM_RAW  = GROUP * NSTG * (NSTG - 1) / 2;
    localparam int REM_BITS = (REM_RAW > 0) ? REM_RAW : 1;

    // Carries as fully expanded sum-of-products; c[i+1] never depends on c[i].
    function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] g,
                                                 input logic [GROUP-1:0] p,
                                                 input logic             cin);
        logic [GROUP:0] c;
        logic           term;
        logic           prod;
        // NOTE: every variable gets a value before any conditional use, so no latch or stale state is implied.
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            term = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = term | (prod & cin);
        end
        return c;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic             in_v_q;
    logic [WIDTH-1:0] in_a_q;
    logic [WIDTH-1:0] in_b_q;
    logic             in_c_q;

    logic [NSTG-1:0]     v_q,   v_d;
    logic [NSTG-1:0]     cy_q,  cy_d;
    logic [SUM_BITS-1:0] sum_q, sum_d;
    logic [REM_BITS-1:0] ra_q,  ra_d;
    logic [REM_BITS-1:0] rb_q,  rb_d;
    logic                msb_q, msb_d;

    // Global enable: the whole pipe freezes only when a result is waiting unaccepted.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign cin_eff  = sub | c_0;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int SOFF = GROUP * k * (k + 1) / 2;
        localparam int SW   = GROUP * (k + 1);
        localparam int RW   = GROUP * (NSTG - 1 - k);

        logic [GROUP-1:0] ga, gb, gg, gp, grp_sum;
        logic [GROUP:0]   gc;
        logic             gcin;
        logic             vin;

        assign gg      = ga & gb;
        assign gp      = ga ^ gb;
        assign gc      = lookahead(gg, gp, gcin);
        assign grp_sum = gp ^ gc[GROUP-1:0];

        assign v_d[k]  = vin;
        assign cy_d[k] = vin ? gc[GROUP] : cy_q[k];

        if (k == 0) begin : g_first
            assign ga   = in_a_q[GROUP-1:0];
            assign gb   = in_b_q[GROUP-1:0];
            assign gcin = in_c_q;
            assign vin  = in_v_q;
            assign sum_d[SOFF +: SW] = vin ? grp_sum : sum_q[SOFF +: SW];
            if (RW > 0) begin : g_rem
                localparam int ROFF = 0;
                assign ra_d[ROFF +: RW] = vin ? in_a_q[WIDTH-1:GROUP] : ra_q[ROFF +: RW];
                assign rb_d[ROFF +: RW] = vin ? in_b_q[WIDTH-1:GROUP] : rb_q[ROFF +: RW];
            end
        end else begin : g_next
            localparam int PSOFF = GROUP * (k - 1) * k / 2;
            localparam int PROFF = GROUP * ((k - 1) * (NSTG - 1) - (k - 1) * (k - 2) / 2);
            assign ga   = ra_q[PROFF +: GROUP];
            assign gb   = rb_q[PROFF +: GROUP];
            assign gcin = cy_q[k-1];
            assign vin  = v_q[k-1];
            assign sum_d[SOFF +: SW] = vin ? {grp_sum, sum_q[PSOFF +: GROUP*k]}
                                           : sum_q[SOFF +: SW];
            if (RW > 0) begin : g_rem
                localparam int ROFF = GROUP * (k * (NSTG - 1) - k * (k - 1) / 2);
                assign ra_d[ROFF +: RW] = vin ? ra_q[PROFF+GROUP +: RW] : ra_q[ROFF +: RW];
                assign rb_d[ROFF +: RW] = vin ? rb_q[PROFF+GROUP +: RW] : rb_q[ROFF +: RW];
            end
        end

        // Carry into the MSB is only meaningful in the group that holds the MSB.
        if (k == NSTG - 1) begin : g_msb
            assign msb_d = vin ? gc[GROUP-1] : msb_q;
        end
    end

    if (REM_RAW == 0) begin : g_no_rem
        assign ra_d = '0;
        assign rb_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all datapath registers are reset too, since the outputs must read zero after reset.
        if (!rst_n) begin
            in_v_q <= 1'b0;
            in_a_q <= '0;
            in_b_q <= '0;
            in_c_q <= 1'b0;
            v_q    <= '0;
            cy_q   <= '0;
            sum_q  <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            msb_q  <= 1'b0;
        end else if (adv) begin
            // NOTE: non-blocking assignments let every stage read last cycle's neighbour values.
            in_v_q <= in_valid;
            if (in_valid) begin
                in_a_q <= a;
                in_b_q <= b_eff;
                in_c_q <= cin_eff;
            end
            v_q   <= v_d;
            cy_q  <= cy_d;
            sum_q <= sum_d;
            ra_q  <= ra_d;
            rb_q  <= rb_d;
            msb_q <= msb_d;
        end
    end

    assign out_valid = v_q[NSTG-1];
    assign sum       = sum_q[SUM_BITS-1 -: WIDTH];
    assign c_out     = cy_q[NSTG-1];
    assign ovf       = msb_q ^ cy_q[NSTG-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed literal cases plus a randomized
// stream compared against an arithmetic reference model through an in-order queue.
module tb_cla_pipe_adder;
    localparam int WIDTH = 16;
    localparam int GROUP = 4;
    localparam int LAT   = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_0;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int n_in    = 0;
    int n_out   = 0;
    int cyc     = 0;

    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH+1:0] head;
    logic             hold_prev = 1'b0;
    logic [WIDTH-1:0] h_sum;
    logic             h_c;
    logic             h_o;

    logic             capture_en = 1'b0;
    int               cap_n      = 0;
    logic [WIDTH-1:0] cap_sum[8];
    int               cap_cyc[8];

    cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_0       (c_0),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {sum, carry out, signed overflow} from plain wide arithmetic.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic ci, input logic s);
        logic [WIDTH-1:0] yy;
        logic [WIDTH:0]   full;
        logic             o;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, (s ? 1'b1 : ci)};
        o    = (x[WIDTH-1] == yy[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return {full[WIDTH-1:0], full[WIDTH], o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single compare process: transfers are judged at the falling edge, where all
    // signals have settled for the coming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            cyc++;
            if (hold_prev) begin
                check("hold_sum", sum, h_sum);
                check("hold_cout", c_out, h_c);
                check("hold_ovf", ovf, h_o);
            end
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (!out_valid) check("idle_in_ready", in_ready, 1);
            if (exp_q.size() == 0) begin
                check("no_spurious_out", out_valid, 0);
            end else if (out_valid) begin
                head = exp_q[0];
                check("result_sum", sum, head[WIDTH+1:2]);
                check("result_cout", c_out, head[1]);
                check("result_ovf", ovf, head[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                    if (capture_en && cap_n < 8) begin
                        cap_sum[cap_n] = sum;
                        cap_cyc[cap_n] = cyc;
                        cap_n++;
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            h_sum     = sum;
            h_c       = c_out;
            h_o       = ovf;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, c_0, sub));
                n_in++;
            end
        end
    end

    task automatic do_single(input string name, input logic [WIDTH-1:0] xa,
                             input logic [WIDTH-1:0] xb, input logic xc, input logic xs,
                             input logic [WIDTH-1:0] esum, input logic ec, input logic eo);
        int lat;
        a = xa; b = xb; c_0 = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
        check({name, "_in_ready"}, in_ready, 1);
        tick();
        // Control inputs change after the accept edge; the result must not follow them.
        in_valid = 1'b0; c_0 = ~xc; sub = ~xs; a = $urandom; b = $urandom;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, lat, LAT);
        check({name, "_sum"}, sum, esum);
        check({name, "_cout"}, c_out, ec);
        check({name, "_ovf"}, ovf, eo);
        tick();
    endtask

    initial begin
        int seen;
        int guard;
        int sent;
        int stall_left;
        bit forced_done;
        bit holding;
        logic [WIDTH+1:0] m;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_0 = 1'b0; sub = 1'b0; out_ready = 1'b0;

        // Pin the model on hand-computed values.
        m = model(16'h1234, 16'h0FCD, 1'b1, 1'b0);
        check("model_add", m, {16'h2202, 1'b0, 1'b0});
        m = model(16'h8000, 16'h0001, 1'b1, 1'b1);
        check("model_sub", m, {16'h7FFF, 1'b1, 1'b1});

        #13;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", c_out, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);

        do_single("add_basic", 16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0);
        do_single("add_carry", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_single("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_single("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_single("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Back-to-back beats at full rate.
        capture_en = 1'b1;
        cap_n      = 0;
        out_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = WIDTH'(i); b = WIDTH'(3 * i); c_0 = 1'b0; sub = 1'b0; in_valid = 1'b1;
            check("b2b_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        guard = 0;
        while (cap_n < 8 && guard < 30) begin
            tick();
            guard++;
        end
        capture_en = 1'b0;
        check("b2b_count", cap_n, 8);
        for (int i = 0; i < 8; i++) begin
            check("b2b_sum", cap_sum[i], 4 * i);
            if (i > 0) check("b2b_consecutive", cap_cyc[i] - cap_cyc[i-1], 1);
        end

        // Reset with a held result at the output and more beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 16'h1111 : WIDTH'($urandom);
            b = (i == 0) ? 16'h2222 : WIDTH'($urandom);
            c_0 = 1'b0; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        check("midrst_held_valid", out_valid, 1);
        check("midrst_held_sum", sum, 16'h3333);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", c_out, 0);
        check("midrst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst_no_stale", seen, 0);

        // Randomized stream with random backpressure and one forced 5-cycle stall.
        n_in = 0; n_out = 0; sent = 0; guard = 0; stall_left = 0;
        forced_done = 1'b0; holding = 1'b0; in_valid = 1'b0;
        while (sent < 200 && guard < 5000) begin
            if (sent == 100 && !forced_done) begin
                stall_left  = 5;
                forced_done = 1'b1;
            end
            out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (stall_left > 0) stall_left--;
            if (!holding) begin
                in_valid = ($urandom_range(0, 3) != 0);
                if (in_valid) begin
                    a = $urandom; b = $urandom; c_0 = $urandom; sub = $urandom;
                end
            end
            @(negedge clk);
            holding = in_valid && !in_ready;
            if (in_valid && in_ready) sent++;
            tick();
            guard++;
        end
        check("stream_sent", sent, 200);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        check("stream_drained", exp_q.size(), 0);
        check("stream_in_count", n_in, 200);
        check("stream_out_count", n_out, n_in);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
